// File: rtl/gc_stream_pkg.sv
// Shared tags, error codes and FSM states for the evaluator-side stream receiver.
package gc_stream_pkg;

  localparam logic [2:0] TAG_NONE = 3'b000;
  localparam logic [2:0] TAG_KEYS = 3'b001;
  localparam logic [2:0] TAG_GT   = 3'b010;
  localparam logic [2:0] TAG_MASK = 3'b011;
  localparam logic       TAG_LBL  = 1'b1;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ORDER = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
  localparam logic [2:0] ERR_COLL  = 3'd3;
  localparam logic [2:0] ERR_SEQ   = 3'd4;
  localparam logic [2:0] ERR_FULL  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/gc_rx_ram.sv
// Synchronous-read RAM with two write ports; port 1 wins on an address clash.
module gc_rx_ram #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          i_we0,
  input  logic [AW-1:0] i_wa0,
  input  logic [DW-1:0] i_wd0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_wa1,
  input  logic [DW-1:0] i_wd1,
  input  logic [AW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
    o_rd <= r_mem[i_ra];
  end

endmodule

// File: rtl/gc_stream_receiver.sv
// Receives the garbler stream: registers it once, then decodes it into keys,
// label RAM, GT RAM banks and the output mask, with per-entry ready flags.
module gc_stream_receiver
  import gc_stream_pkg::*;
#(
  parameter int S  = 20,
  parameter int K  = 128,
  parameter int LA = 10,
  parameter int GA = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic [2:0]     tag,
  input  logic [S-1:0]   index0,
  input  logic [S-1:0]   index1,
  input  logic [K-1:0]   data0,
  input  logic [K-1:0]   data1,
  output logic [K-1:0]   R,
  output logic [K-1:0]   aes_key,
  output logic           key_valid,
  input  logic [LA-1:0]  lbl_rd_addr,
  output logic [K-1:0]   lbl_rd_data,
  output logic           lbl_rd_vld,
  input  logic [GA-2:0]  gt_rd_index,
  output logic [K-1:0]   gt_rd_data0,
  output logic [K-1:0]   gt_rd_data1,
  output logic           gt_rd_vld,
  output logic [GA-2:0]  gt_count,
  output logic [2*K-1:0] mask,
  output logic           mask_valid,
  output logic           err,
  output logic [2:0]     err_code
);

  localparam int GW     = GA - 1;
  localparam int LDEPTH = 1 << LA;

  logic [2:0]        r_tag_p1;
  logic [S-1:0]      r_idx0_p1, r_idx1_p1;
  logic [K-1:0]      r_d0_p1, r_d1_p1;

  state_t            r_state, w_state_nxt;
  logic [K-1:0]      r_R, r_aes;
  logic              r_key_valid, r_mask_valid, r_err;
  logic [2*K-1:0]    r_mask;
  logic [2:0]        r_err_code;
  logic [GW-1:0]     r_gt_count;
  logic [LDEPTH-1:0] r_lbl_flag;
  logic              r_lbl_rd_vld, r_gt_rd_vld;

  logic              w_lbl, w_v0, w_v1, w_ok0, w_ok1, w_same;
  logic              w_key_cap, w_mask_cap, w_gt_wr, w_l0_we, w_l1_we, w_err_set;
  logic [2:0]        w_err_cause;
  logic [S-1:0]      w_exp0;

  // Stage 1: register the raw stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_tag_p1 <= TAG_NONE;
    else if (clear) r_tag_p1 <= TAG_NONE;
    else            r_tag_p1 <= tag;
  end

  always_ff @(posedge clk) begin
    r_idx0_p1 <= index0;
    r_idx1_p1 <= index1;
    r_d0_p1   <= data0;
    r_d1_p1   <= data1;
  end

  // Stage 2: decode, FSM and RAM/flag writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_state <= ST_IDLE;
    else if (clear) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (r_tag_p1 == TAG_KEYS) w_state_nxt = ST_RECEIVE;
      ST_RECEIVE: if (r_tag_p1 == TAG_MASK) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_exp0 = S'({r_gt_count, 1'b0});

  always_comb begin
    w_lbl       = (r_tag_p1[2] == TAG_LBL);
    w_v0        = r_tag_p1[0];
    w_v1        = r_tag_p1[1];
    w_ok0       = w_v0 && (r_idx0_p1[S-1:LA] == '0);
    w_ok1       = w_v1 && (r_idx1_p1[S-1:LA] == '0);
    w_same      = w_ok0 && w_ok1 && (r_idx0_p1 == r_idx1_p1);
    w_key_cap   = 1'b0;
    w_mask_cap  = 1'b0;
    w_gt_wr     = 1'b0;
    w_l0_we     = 1'b0;
    w_l1_we     = 1'b0;
    w_err_set   = 1'b0;
    w_err_cause = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (r_tag_p1 == TAG_KEYS) begin
          w_key_cap = 1'b1;
        end else if (r_tag_p1 != TAG_NONE) begin
          w_err_set   = 1'b1;
          w_err_cause = ERR_ORDER;
        end
      end
      ST_RECEIVE: begin
        if (w_lbl) begin
          // On a collision only port 1 writes, so port 1's data wins
          w_l0_we = w_ok0 && !w_same;
          w_l1_we = w_ok1;
          if ((w_v0 && !w_ok0) || (w_v1 && !w_ok1)) begin
            w_err_set   = 1'b1;
            w_err_cause = ERR_RANGE;
          end else if (w_same) begin
            w_err_set   = 1'b1;
            w_err_cause = ERR_COLL;
          end
        end else if (r_tag_p1 == TAG_KEYS) begin
          w_err_set   = 1'b1;
          w_err_cause = ERR_ORDER;
        end else if (r_tag_p1 == TAG_GT) begin
          if (r_gt_count == '1) begin
            w_err_set   = 1'b1;
            w_err_cause = ERR_FULL;
          end else begin
            w_gt_wr = 1'b1;
            if (r_idx0_p1 != w_exp0 || r_idx1_p1 != w_exp0 + S'(1)) begin
              w_err_set   = 1'b1;
              w_err_cause = ERR_SEQ;
            end
          end
        end else if (r_tag_p1 == TAG_MASK) begin
          w_mask_cap = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_lbl || r_tag_p1 == TAG_KEYS) begin
          w_err_set   = 1'b1;
          w_err_cause = ERR_ORDER;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_R          <= '0;
      r_aes        <= '0;
      r_key_valid  <= 1'b0;
      r_mask       <= '0;
      r_mask_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_gt_count   <= '0;
      r_lbl_flag   <= '0;
      r_lbl_rd_vld <= 1'b0;
      r_gt_rd_vld  <= 1'b0;
    end else if (clear) begin
      r_R          <= '0;
      r_aes        <= '0;
      r_key_valid  <= 1'b0;
      r_mask       <= '0;
      r_mask_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_gt_count   <= '0;
      r_lbl_flag   <= '0;
      r_lbl_rd_vld <= 1'b0;
      r_gt_rd_vld  <= 1'b0;
    end else begin
      if (w_key_cap) begin
        r_R         <= r_d0_p1;
        r_aes       <= r_d1_p1;
        r_key_valid <= 1'b1;
      end
      if (w_mask_cap) begin
        r_mask       <= {r_d0_p1, r_d1_p1};
        r_mask_valid <= 1'b1;
      end
      if (w_gt_wr) r_gt_count <= r_gt_count + GW'(1);
      if (w_err_set && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_cause;
      end
      if (w_l0_we) r_lbl_flag[r_idx0_p1[LA-1:0]] <= 1'b1;
      if (w_l1_we) r_lbl_flag[r_idx1_p1[LA-1:0]] <= 1'b1;
      // Read-side flags sample the pre-write state, matching the RAM's old-data read
      r_lbl_rd_vld <= r_lbl_flag[lbl_rd_addr];
      r_gt_rd_vld  <= (gt_rd_index < r_gt_count);
    end
  end

  gc_rx_ram #(.AW(LA), .DW(K)) u_lbl_ram (
    .clk   (clk),
    .i_we0 (w_l0_we),
    .i_wa0 (r_idx0_p1[LA-1:0]),
    .i_wd0 (r_d0_p1),
    .i_we1 (w_l1_we),
    .i_wa1 (r_idx1_p1[LA-1:0]),
    .i_wd1 (r_d1_p1),
    .i_ra  (lbl_rd_addr),
    .o_rd  (lbl_rd_data)
  );

  gc_rx_ram #(.AW(GW), .DW(K)) u_gt_even (
    .clk   (clk),
    .i_we0 (w_gt_wr),
    .i_wa0 (r_gt_count),
    .i_wd0 (r_d0_p1),
    .i_we1 (1'b0),
    .i_wa1 ('0),
    .i_wd1 ('0),
    .i_ra  (gt_rd_index),
    .o_rd  (gt_rd_data0)
  );

  gc_rx_ram #(.AW(GW), .DW(K)) u_gt_odd (
    .clk   (clk),
    .i_we0 (w_gt_wr),
    .i_wa0 (r_gt_count),
    .i_wd0 (r_d1_p1),
    .i_we1 (1'b0),
    .i_wa1 ('0),
    .i_wd1 ('0),
    .i_ra  (gt_rd_index),
    .o_rd  (gt_rd_data1)
  );

  assign R          = r_R;
  assign aes_key    = r_aes;
  assign key_valid  = r_key_valid;
  assign lbl_rd_vld = r_lbl_rd_vld;
  assign gt_rd_vld  = r_gt_rd_vld;
  assign gt_count   = r_gt_count;
  assign mask       = r_mask;
  assign mask_valid = r_mask_valid;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_gc_stream_receiver.sv
// Scoreboard bench for gc_stream_receiver: a transaction-level model predicts
// every read port and status output; a negedge monitor compares them.
module tb_gc_stream_receiver;

  localparam logic [19:0] NU = 20'hFFFFF;
  localparam int KLV = 0, KLD = 1, KGV = 2, KG0 = 3, KG1 = 4, KKV = 5, KR = 6;
  localparam int KAES = 7, KCNT = 8, KERR = 9, KCODE = 10, KMV = 11, KMASK = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic [2:0]   tag = 3'b000;
  logic [19:0]  index0 = NU, index1 = NU;
  logic [127:0] data0 = '0, data1 = '0;
  logic [127:0] R, aes_key, lbl_rd_data, gt_rd_data0, gt_rd_data1;
  logic         key_valid, lbl_rd_vld, gt_rd_vld, mask_valid, err;
  logic [9:0]   lbl_rd_addr = '0, gt_rd_index = '0, gt_count;
  logic [255:0] mask;
  logic [2:0]   err_code;

  gc_stream_receiver dut (
    .clk(clk), .rst(rst), .clear(clear), .tag(tag), .index0(index0), .index1(index1),
    .data0(data0), .data1(data1), .R(R), .aes_key(aes_key), .key_valid(key_valid),
    .lbl_rd_addr(lbl_rd_addr), .lbl_rd_data(lbl_rd_data), .lbl_rd_vld(lbl_rd_vld),
    .gt_rd_index(gt_rd_index), .gt_rd_data0(gt_rd_data0), .gt_rd_data1(gt_rd_data1),
    .gt_rd_vld(gt_rd_vld), .gt_count(gt_count), .mask(mask), .mask_valid(mask_valid),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int kind; logic [255:0] exp; } item_t;
  typedef struct { int eg; logic [2:0] t; logic [19:0] i0; logic [19:0] i1; logic [127:0] d0; logic [127:0] d1; } pend_t;

  item_t sb[$];
  pend_t pend[$];
  int tests = 0, failed = 0;

  // Reference model state (stream visible to reads two edges after its tag edge)
  int           m_state, m_cnt, m_code;
  bit           m_kv, m_mv, m_err;
  logic [127:0] m_R, m_aes;
  logic [255:0] m_mask;
  logic [127:0] m_lbl [int];
  logic [127:0] m_g0 [int];
  logic [127:0] m_g1 [int];

  function automatic void m_reset();
    m_state = 0; m_cnt = 0; m_code = 0; m_kv = 0; m_mv = 0; m_err = 0;
    m_R = '0; m_aes = '0; m_mask = '0;
    m_lbl.delete(); m_g0.delete(); m_g1.delete();
  endfunction

  function automatic void seterr(int c);
    if (!m_err) begin m_err = 1; m_code = c; end
  endfunction

  function automatic void apply(input pend_t p);
    bit lbl, ok0, ok1, same;
    lbl  = p.t[2];
    ok0  = p.t[0] && (int'(p.i0) < 1024);
    ok1  = p.t[1] && (int'(p.i1) < 1024);
    same = ok0 && ok1 && (p.i0 == p.i1);
    if (m_state == 0) begin
      if (p.t == 3'b001) begin m_R = p.d0; m_aes = p.d1; m_kv = 1; m_state = 1; end
      else if (p.t != 3'b000) seterr(1);
    end else if (m_state == 1) begin
      if (lbl) begin
        if ((p.t[0] && !ok0) || (p.t[1] && !ok1)) seterr(2);
        else if (same) seterr(3);
        if (ok0) m_lbl[int'(p.i0)] = p.d0;
        if (ok1) m_lbl[int'(p.i1)] = p.d1;
      end else if (p.t == 3'b001) seterr(1);
      else if (p.t == 3'b010) begin
        if (m_cnt == 1023) seterr(5);
        else begin
          if (int'(p.i0) != 2 * m_cnt || int'(p.i1) != int'(p.i0) + 1) seterr(4);
          m_g0[m_cnt] = p.d0; m_g1[m_cnt] = p.d1; m_cnt++;
        end
      end else if (p.t == 3'b011) begin
        m_mask = {p.d0, p.d1}; m_mv = 1; m_state = 2;
      end
    end else begin
      if (lbl || p.t == 3'b001) seterr(1);
    end
  endfunction

  function automatic void apply_upto(int e);
    while (pend.size() > 0 && pend[0].eg <= e) apply(pend.pop_front());
  endfunction

  function automatic void push(int due, int kind, logic [255:0] e);
    sb.push_back('{due, kind, e});
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic string kname(int k);
    case (k)
      KLV: return "lbl_rd_vld";   KLD: return "lbl_rd_data"; KGV: return "gt_rd_vld";
      KG0: return "gt_rd_data0";  KG1: return "gt_rd_data1"; KKV: return "key_valid";
      KR: return "R";             KAES: return "aes_key";    KCNT: return "gt_count";
      KERR: return "err";         KCODE: return "err_code";  KMV: return "mask_valid";
      default: return "mask";
    endcase
  endfunction

  function automatic logic [255:0] actual(int k);
    case (k)
      KLV: return 256'(lbl_rd_vld);   KLD: return 256'(lbl_rd_data);
      KGV: return 256'(gt_rd_vld);    KG0: return 256'(gt_rd_data0);
      KG1: return 256'(gt_rd_data1);  KKV: return 256'(key_valid);
      KR: return 256'(R);             KAES: return 256'(aes_key);
      KCNT: return 256'(gt_count);    KERR: return 256'(err);
      KCODE: return 256'(err_code);   KMV: return 256'(mask_valid);
      default: return mask;
    endcase
  endfunction

  item_t it;
  logic [255:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      act = actual(it.kind);
      tests++;
      if (it.due != cyc || act !== it.exp) begin
        failed++;
        $display("FAIL %s cyc=%0d due=%0d got=%0h want=%0h", kname(it.kind), cyc, it.due, act, it.exp);
      end
    end
  end

  task automatic step(input logic [2:0] t, input logic [19:0] i0, input logic [19:0] i1,
                      input logic [127:0] a, input logic [127:0] b,
                      input logic [9:0] ra, input logic [9:0] gi, input bit chk);
    int m;
    m = cyc + 1;
    tag = t; index0 = i0; index1 = i1; data0 = a; data1 = b;
    lbl_rd_addr = ra; gt_rd_index = gi;
    apply_upto(m - 2);
    if (chk) begin
      push(m, KLV, 256'(m_lbl.exists(int'(ra))));
      if (m_lbl.exists(int'(ra))) push(m, KLD, 256'(m_lbl[int'(ra)]));
      push(m, KGV, 256'(int'(gi) < m_cnt));
      if (int'(gi) < m_cnt) begin
        push(m, KG0, 256'(m_g0[int'(gi)]));
        push(m, KG1, 256'(m_g1[int'(gi)]));
      end
    end
    pend.push_back('{m, t, i0, i1, a, b});
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [2:0] t, input logic [19:0] i0, input logic [19:0] i1,
                    input logic [127:0] a, input logic [127:0] b);
    step(t, i0, i1, a, b, 10'($urandom_range(0, 31)), 10'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic rd(input logic [9:0] ra, input logic [9:0] gi);
    step(3'b000, NU, NU, '0, '0, ra, gi, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) st(3'b000, NU, NU, '0, '0);
  endtask

  task automatic chk_status();
    apply_upto(cyc - 1);
    push(cyc, KKV, 256'(m_kv));   push(cyc, KR, 256'(m_R));     push(cyc, KAES, 256'(m_aes));
    push(cyc, KCNT, 256'(m_cnt)); push(cyc, KERR, 256'(m_err)); push(cyc, KCODE, 256'(m_code));
    push(cyc, KMV, 256'(m_mv));   push(cyc, KMASK, m_mask);
  endtask

  task automatic do_clear();
    idle(2);
    clear = 1'b1;
    step(3'b000, NU, NU, '0, '0, '0, '0, 1'b0);
    clear = 1'b0;
    m_reset();
    pend.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++; failed++;
      $display("FAIL drain pending=%0d want=0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  logic [2:0]  rt;
  logic [19:0] ri0, ri1, gnext;
  int          rr;

  initial begin
    // Reset state while rst is held low
    m_reset();
    @(posedge clk); #1;
    chk_status();
    push(cyc, KLV, '0); push(cyc, KGV, '0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Keys then labels
    st(3'b001, NU, NU, 128'h1, {16{8'hAA}});
    st(3'b111, 20'd0, 20'd1, 128'h11, 128'h22);
    chk_status();
    rd(10'd1, '0); rd(10'd1, '0); rd(10'd5, '0); rd(10'd0, '0);

    // GT sequence, then out-of-sequence pair
    st(3'b010, 20'd0, 20'd1, r128(), r128());
    st(3'b010, 20'd2, 20'd3, r128(), r128());
    st(3'b010, 20'd4, 20'd5, r128(), r128());
    idle(2); chk_status();
    st(3'b010, 20'd8, 20'd9, r128(), r128());
    idle(2); chk_status();
    rd('0, 10'd3); rd('0, 10'd2); rd('0, 10'd4);

    // Masks, then ignored GT and a label in DONE
    st(3'b011, NU, NU, {16{8'hF0}}, {16{8'h0F}});
    idle(2); chk_status();
    st(3'b010, 20'd10, 20'd11, r128(), r128());
    st(3'b101, 20'd9, NU, r128(), r128());
    idle(2); chk_status();

    // Ordering: label before keys, keys still accepted
    do_clear();
    st(3'b101, 20'd4, NU, r128(), r128());
    idle(1); rd(10'd4, '0); chk_status();
    st(3'b001, NU, NU, r128(), r128());
    idle(2); chk_status();

    // Collision then out-of-range; first cause kept
    do_clear();
    st(3'b001, NU, NU, r128(), r128());
    st(3'b111, 20'd7, 20'd7, 128'hD0, 128'hD1);
    idle(1); rd(10'd7, '0); chk_status();
    st(3'b101, 20'd1024, NU, r128(), r128());
    idle(1); rd(10'd0, '0); chk_status();

    // Asynchronous reset mid-stream
    do_clear();
    st(3'b001, NU, NU, r128(), r128());
    st(3'b010, 20'd0, 20'd1, r128(), r128());
    st(3'b010, 20'd2, 20'd3, r128(), r128());
    for (int i = 0; i < 3; i++) step(3'b000, NU, NU, '0, '0, '0, '0, 1'b0);
    drain();
    @(posedge clk); #3;
    rst = 1'b0;
    m_reset(); pend.delete();
    chk_status();
    push(cyc, KLV, '0); push(cyc, KGV, '0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    st(3'b010, 20'd0, 20'd1, r128(), r128());
    idle(2); chk_status();

    // Randomized session
    do_clear();
    st(3'b001, NU, NU, r128(), r128());
    gnext = '0;
    for (int n = 0; n < 400; n++) begin
      rr = $urandom_range(0, 99);
      rt = 3'b000; ri0 = NU; ri1 = NU;
      if (rr >= 25 && rr < 55) begin
        rt = {1'b1, 2'($urandom_range(0, 3))};
        if (rt[0]) ri0 = ($urandom_range(0, 19) == 0) ? 20'd1024 : 20'($urandom_range(0, 31));
        if (rt[1]) ri1 = 20'($urandom_range(0, 31));
      end else if (rr >= 55 && rr < 85) begin
        rt = 3'b010;
        if ($urandom_range(0, 9) != 0) begin ri0 = gnext << 1; ri1 = (gnext << 1) + 20'd1; end
        else begin ri0 = 20'($urandom_range(0, 63)); ri1 = 20'($urandom_range(0, 63)); end
        gnext = gnext + 20'd1;
      end else if (rr >= 85 && rr < 88) begin
        rt = 3'b001;
      end
      st(rt, ri0, ri1, r128(), r128());
      if (n % 16 == 15) chk_status();
    end
    st(3'b011, NU, NU, r128(), r128());
    idle(2); chk_status();

    // GT table fills to its last usable count, then the next pair is refused
    do_clear();
    st(3'b001, NU, NU, r128(), r128());
    for (int i = 0; i < 1023; i++)
      step(3'b010, 20'(2 * i), 20'(2 * i + 1), r128(), r128(),
           10'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)), 1'b1);
    st(3'b010, 20'd2046, 20'd2047, r128(), r128());
    idle(2); chk_status();
    rd('0, 10'd1022); rd('0, 10'd1023); rd('0, 10'd0);

    idle(2);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gc_stream_receiver.md
Name: gc_stream_receiver

Overview:
Evaluator-side receiver for the garbler's output stream (tag/index0/index1/data0/data1). Each cycle it decodes the tag and captures the payload:
- global keys (R, AES key);
- input/constant labels, into a label RAM;
- garbled-table rows, into a GT RAM;
- the output-mask word.

Read ports with per-entry ready flags let the evaluation engine stall until the data it needs has arrived.

Parameters:
S, 20, index width of the stream (matches garbler S)
K, 128, label/data width
LA, 10, log2 label RAM depth (entries 0..2**LA-1; 0/1 are constant labels)
GA, 11, log2 GT RAM depth in rows (two rows per non-XOR gate)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
clear  in  1  synchronous session clear: returns to IDLE, clears all flags/counters
tag  in  3  stream tag: 000 none, 001 keys, 010 GT pair, 011 masks, 1xy labels (x=idx1 valid, y=idx0 valid)
index0  in  S  stream index 0 (all-ones when unused)
index1  in  S  stream index 1
data0  in  K  stream payload 0
data1  in  K  stream payload 1
R  out  K  received global offset R
aes_key  out  K  received AES key
key_valid  out  1  keys captured
lbl_rd_addr  in  LA  label read address
lbl_rd_data  out  K  label read data, 1-cycle latency
lbl_rd_vld  out  1  addressed label was written before the read cycle (same latency as data)
gt_rd_index  in  GA-1  gate-table read index (rows 2i, 2i+1)
gt_rd_data0  out  K  row 2i, 1-cycle latency
gt_rd_data1  out  K  row 2i+1
gt_rd_vld  out  1  registered (gt_rd_index < gt_count)
gt_count  out  GA-1  number of GT pairs received
mask  out  2K  output mask bits, {data0,data1}, mask[2K-1] = first data0 bit
mask_valid  out  1  mask word captured; session done
err  out  1  sticky protocol error
err_code  out  3  first error cause (package constants)

Behaviour:
- Reset (rst=0, async):
  - state IDLE;
  - R, aes_key, mask = 0;
  - key_valid, mask_valid, err, gt_rd_vld, lbl_rd_vld = 0;
  - err_code = 0; gt_count = 0;
  - label-flag bitmap all 0.
  - RAM contents are undefined after reset.
  - `clear` performs the same actions synchronously, and has priority over the stream in that cycle.
- Input stage: tag/index/data are registered once (stage 1). Decode and RAM/flag writes occur in stage 2. A label is therefore readable, with vld=1, on a read issued 2 cycles after its tag cycle. Read data appears 1 cycle after the address.
- FSM states: IDLE, RECEIVE, DONE.
  - IDLE + keys tag: capture R=data0, aes_key=data1, key_valid=1, go to RECEIVE.
  - IDLE + any other non-zero tag: ERR_ORDER, tag dropped.
  - RECEIVE + keys tag: ERR_ORDER, keys unchanged.
  - RECEIVE + label tag:
    - write data0 at index0 if bit0 is set, and data1 at index1 if bit1 is set; set the corresponding flags.
    - Out-of-range index (>= 2**LA): that write is dropped, ERR_RANGE.
    - index0 == index1 with both valid: port1 wins, ERR_COLL.
  - RECEIVE + GT tag:
    - required: index0 == 2*gt_count and index1 == index0+1; otherwise ERR_SEQ, but the pair is still written at slot gt_count.
    - gt_count increments.
    - gt_count at its maximum: ERR_FULL, pair dropped, no wrap.
  - RECEIVE + masks tag: mask={data0,data1}, mask_valid=1, go to DONE.
  - DONE: all tags ignored, except that keys or label tags raise ERR_ORDER. Only clear or rst leaves DONE.
- tag 000 is always a no-op.
- err latches on the first error; err_code holds the first cause; later errors are ignored.
- Read vs write, same address, same cycle: the read returns old data, and vld reflects the pre-write flag.
- The two label write ports are independent; the RAM is 2W1R.

Decomposition:
- Package gc_stream_pkg holds:
  - tag localparams: TAG_NONE, TAG_KEYS, TAG_GT, TAG_MASK, TAG_LBL prefix;
  - error codes: ERR_NONE=0, ERR_ORDER=1, ERR_RANGE=2, ERR_COLL=3, ERR_SEQ=4, ERR_FULL=5;
  - the FSM state enum.
- One sub-module, gc_rx_ram (parameterised depth/width, sync read, two write ports), instantiated for labels (2W) and for GT as two banks (even/odd rows, 1W each).

Test Plan:
1. Keys then labels: keys R=0x…01, key=0xAA…; label tag 111 idx 0/1 data 0x11/0x22 → key_valid=1 next cycle; reading addr 1 two cycles later gives 0x22 with vld=1; addr 5 gives vld=0.
2. GT sequence: three GT tags with idx (0,1),(2,3),(4,5) → gt_count=3, err=0. A fourth tag with idx (8,9) → ERR_SEQ, gt_count=4, data stored at pair 3.
3. Ordering: label tag 101 before keys → err=1, code=1, no flag set. A later keys tag is still accepted.
4. Masks: mask tag data0=0xF0…, data1=0x0F… → mask_valid=1, state DONE. A subsequent GT tag is ignored and gt_count is unchanged.
5. Collisions/range: tag 111 idx0=idx1=7 → addr 7 holds data1, code=3. idx0=2**LA → dropped; err_code stays 3 (first cause).
6. Reset mid-stream: rst=0 after 2 GT pairs → all outputs 0 asynchronously. After release, a GT tag before keys → ERR_ORDER.
